mips_inst_encoder: RTL and testbench

MIPS_INST_ENCODER -- requirements
Module: mips_inst_encoder

---
 rtl/mips_inst_encoder.sv | 143 ++++++++++++++
 tb/tb_mips_inst_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder
// Streams decoded instruction fields in, encodes each into a 32-bit MIPS
// word and writes it to instruction memory at consecutive word addresses.
//
// Ports:
//   clock, resetn            clock, asynchronous active-low reset
//   start, base_addr         begin a load session at base_addr (word aligned)
//   in_valid/in_ready        instruction-field handshake
//   in_last                  final instruction of the session
//   in_mnem, in_rs, in_rt,
//   in_rd, in_sa, in_imm,
//   in_target                instruction code and fields
//   im_we/im_ready           memory write handshake
//   im_addr, im_wdata        write address and encoded word
//   busy, done, count        session status, words written this session
//   err_illegal              sticky flag for illegal instruction codes
module mips_inst_encoder (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [4:0]  in_mnem,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_sa,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        im_we,
    input  logic        im_ready,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  count,
    output logic        err_illegal
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        wr_done;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa,
                                           input logic [5:0] func);
        return {6'b000000, rs, rt, rd, sa, func};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    assign accept   = in_valid & in_ready;
    assign wr_done  = im_we & im_ready;
    // Output register may be refilled in the same cycle it drains.
    assign in_ready = (state == LOAD) & (~im_we | im_ready);
    assign busy     = (state != IDLE);

    // Field encoder; unused fields are forced to zero per instruction class.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_mnem)
            5'd0:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100000);
            5'd1:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100010);
            5'd2:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100100);
            5'd3:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100101);
            5'd4:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100110);
            5'd5:  enc_word = r_word(5'd0, in_rt, in_rd, in_sa, 6'b000000);
            5'd6:  enc_word = r_word(5'd0, in_rt, in_rd, in_sa, 6'b000010);
            5'd7:  enc_word = r_word(5'd0, in_rt, in_rd, in_sa, 6'b000011);
            5'd8:  enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'b001000);
            5'd9:  enc_word = i_word(6'b001000, in_rs, in_rt, in_imm);
            5'd10: enc_word = i_word(6'b001100, in_rs, in_rt, in_imm);
            5'd11: enc_word = i_word(6'b001101, in_rs, in_rt, in_imm);
            5'd12: enc_word = i_word(6'b001110, in_rs, in_rt, in_imm);
            5'd13: enc_word = i_word(6'b100011, in_rs, in_rt, in_imm);
            5'd14: enc_word = i_word(6'b101011, in_rs, in_rt, in_imm);
            5'd15: enc_word = i_word(6'b000100, in_rs, in_rt, in_imm);
            5'd16: enc_word = i_word(6'b000101, in_rs, in_rt, in_imm);
            5'd17: enc_word = i_word(6'b001111, 5'd0, in_rt, in_imm);
            5'd18: enc_word = {6'b000010, in_target};
            5'd19: enc_word = {6'b000011, in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD:  if (accept && in_last) state_nxt = DRAIN;
            DRAIN: if (!im_we) begin
                       state_nxt = IDLE;
                       done      = 1'b1;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_wdata    <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                // Output register is always empty in IDLE, so no write can race this.
                im_addr     <= {base_addr[31:2], 2'b00};
                count       <= '0;
                err_illegal <= 1'b0;
            end else begin
                // im_addr always points at the pending (or next) word.
                if (wr_done) begin
                    im_addr <= im_addr + 32'd4;
                    count   <= count + 8'd1;
                end
                if (accept && enc_legal) begin
                    im_we    <= 1'b1;
                    im_wdata <= enc_word;
                end else if (wr_done) begin
                    im_we <= 1'b0;
                end
                if (accept && !enc_legal)
                    err_illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_inst_encoder.sv
module tb_mips_inst_encoder;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [4:0]  in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_sa = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        im_we;
    logic        im_ready = 1'b1;
    logic [31:0] im_addr, im_wdata;
    logic        busy, done, err_illegal;
    logic [7:0]  count;

    int total = 0;
    int bad = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    mips_inst_encoder dut (
        .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
        .in_imm(in_imm), .in_target(in_target),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .count(count), .err_illegal(err_illegal)
    );

    always #5 clock = ~clock;

    // Record every completed memory write.
    always @(posedge clock)
        if (resetn && im_we === 1'b1 && im_ready === 1'b1) begin
            wq_addr.push_back(im_addr);
            wq_data.push_back(im_wdata);
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic do_start(input logic [31:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                             input logic [25:0] tgt, input logic last);
        int n;
        in_mnem = mn; in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa;
        in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL beat_accept: in_ready=%b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 30) begin tick(); n++; end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL wait_done: done=%b want 1 (timeout)", done); end
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        total++; if (im_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", im_we); end
        total++; if (im_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", im_addr); end
        total++; if (im_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", im_wdata); end
        total++; if (count !== 8'h0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        total++; if ({busy, done, err_illegal, in_ready} !== 4'b0) begin bad++; $display("FAIL rst_flags: got %b want 0000", {busy, done, err_illegal, in_ready}); end
        resetn = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL idle_after_rst: busy=%b in_ready=%b want 0 0", busy, in_ready); end
    endtask

    task automatic test_single();
        im_ready = 1'b1;
        clear_q();
        do_start(32'h0000_0100);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        send_beat(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        total++; if (im_we !== 1'b1) begin bad++; $display("FAIL single_we: got %b want 1", im_we); end
        total++; if (im_addr !== 32'h0000_0100) begin bad++; $display("FAIL single_addr: got %h want 00000100", im_addr); end
        total++; if (im_wdata !== 32'h0022_1820) begin bad++; $display("FAIL single_data: got %h want 00221820", im_wdata); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done: got %b want 1", done); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_end: done=%b busy=%b want 0 0", done, busy); end
        total++; if (count !== 8'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
        total++; if (wq_addr.size() != 1) begin bad++; $display("FAIL single_nwrites: got %0d want 1", wq_addr.size()); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_d [4] = '{32'h8FA8_0004, 32'h0001_1100, 32'h3C05_1234, 32'h0800_0010};
        im_ready = 1'b1;
        clear_q();
        do_start(32'h0000_0000);
        send_beat(5'd13, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
        send_beat(5'd5,  5'd9,  5'd1, 5'd2, 5'd4, 16'h0,    26'h0, 1'b0);  // rs must be forced to 0
        send_beat(5'd17, 5'd7,  5'd5, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);  // rs must be forced to 0
        send_beat(5'd18, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0,    26'h10, 1'b1);
        wait_done();
        total++; if (wq_addr.size() != 4) begin bad++; $display("FAIL stream_nwrites: got %0d want 4", wq_addr.size()); end
        for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
            total++; if (wq_addr[i] !== 32'(4 * i)) begin bad++; $display("FAIL stream_addr[%0d]: got %h want %h", i, wq_addr[i], 32'(4 * i)); end
            total++; if (wq_data[i] !== exp_d[i]) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, wq_data[i], exp_d[i]); end
        end
        total++; if (count !== 8'd4) begin bad++; $display("FAIL stream_count: got %0d want 4", count); end
    endtask

    task automatic test_encode();
        logic [4:0]  mn [10] = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14, 5'd16};
        logic [4:0]  rs [10] = '{5'd7, 5'd1, 5'd2, 5'd9, 5'd1, 5'd31, 5'd3, 5'd0, 5'd29, 5'd4};
        logic [4:0]  rt [10] = '{5'd8, 5'd1, 5'd3, 5'd10, 5'd2, 5'd5, 5'd4, 5'd0, 5'd31, 5'd0};
        logic [4:0]  rd [10] = '{5'd9, 5'd1, 5'd4, 5'd11, 5'd3, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [4:0]  sa [10] = '{5'd3, 5'd0, 5'd0, 5'd31, 5'd1, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [15:0] im [10] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'hABCD, 16'hFFFC, 16'h0003};
        logic [31:0] ex [10] = '{32'h00E8_4822, 32'h0021_0824, 32'h0043_2025, 32'h000A_5FC3, 32'h0002_1842,
                                 32'h03E0_0008, 32'h3064_8000, 32'h3800_ABCD, 32'hAFBF_FFFC, 32'h1480_0003};
        logic [31:0] ea;
        im_ready = 1'b1;
        clear_q();
        do_start(32'hFFFF_FFF8);  // address wraps through zero mid-session
        for (int i = 0; i < 10; i++)
            send_beat(mn[i], rs[i], rt[i], rd[i], sa[i], im[i], 26'h0, i == 9);
        wait_done();
        total++; if (wq_addr.size() != 10) begin bad++; $display("FAIL enc_nwrites: got %0d want 10", wq_addr.size()); end
        for (int i = 0; i < 10 && i < wq_addr.size(); i++) begin
            ea = 32'hFFFF_FFF8 + 32'(4 * i);
            total++; if (wq_addr[i] !== ea) begin bad++; $display("FAIL enc_addr[%0d]: got %h want %h", i, wq_addr[i], ea); end
            total++; if (wq_data[i] !== ex[i]) begin bad++; $display("FAIL enc_data[%0d]: got %h want %h", i, wq_data[i], ex[i]); end
        end
        total++; if (count !== 8'd10) begin bad++; $display("FAIL enc_count: got %0d want 10", count); end
    endtask

    task automatic test_stall();
        im_ready = 1'b0;
        clear_q();
        do_start(32'h0000_0200);
        send_beat(5'd11, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b0);
        // Next beat waits while memory stalls.
        in_mnem = 5'd15; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'hFFFE; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", c, in_ready); end
            total++; if (im_we !== 1'b1 || im_addr !== 32'h200 || im_wdata !== 32'h3443_00FF) begin
                bad++; $display("FAIL stall_hold[%0d]: we=%b addr=%h data=%h want 1 00000200 344300ff", c, im_we, im_addr, im_wdata); end
            tick();
        end
        im_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release: in_ready=%b want 1", in_ready); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (im_we !== 1'b1 || im_addr !== 32'h204 || im_wdata !== 32'h1022_FFFE) begin
            bad++; $display("FAIL stall_second: we=%b addr=%h data=%h want 1 00000204 1022fffe", im_we, im_addr, im_wdata); end
        wait_done();
        total++; if (wq_addr.size() != 2) begin bad++; $display("FAIL stall_nwrites: got %0d want 2", wq_addr.size()); end
        total++; if (count !== 8'd2) begin bad++; $display("FAIL stall_count: got %0d want 2", count); end
    endtask

    task automatic test_illegal();
        im_ready = 1'b1;
        clear_q();
        do_start(32'h0000_0300);
        send_beat(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0, 1'b0);
        total++; if (im_we !== 1'b0 || err_illegal !== 1'b1) begin bad++; $display("FAIL ill_drop: we=%b err=%b want 0 1", im_we, err_illegal); end
        total++; if (count !== 8'd0 || im_addr !== 32'h300) begin bad++; $display("FAIL ill_state: count=%0d addr=%h want 0 00000300", count, im_addr); end
        send_beat(5'd9, 5'd0, 5'd1, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1);
        wait_done();
        total++; if (wq_addr.size() != 1) begin bad++; $display("FAIL ill_nwrites: got %0d want 1", wq_addr.size()); end
        else begin
            total++; if (wq_addr[0] !== 32'h300 || wq_data[0] !== 32'h2001_FFFF) begin
                bad++; $display("FAIL ill_write: addr=%h data=%h want 00000300 2001ffff", wq_addr[0], wq_data[0]); end
        end
        total++; if (count !== 8'd1 || err_illegal !== 1'b1) begin bad++; $display("FAIL ill_end: count=%0d err=%b want 1 1", count, err_illegal); end
        clear_q();
        do_start(32'h0000_0600);
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL ill_clear: err=%b want 0", err_illegal); end
        // Illegal code carrying last still ends the session.
        send_beat(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        wait_done();
        total++; if (busy !== 1'b0 || count !== 8'd0 || wq_addr.size() != 0) begin
            bad++; $display("FAIL ill_last: busy=%b count=%0d writes=%0d want 0 0 0", busy, count, wq_addr.size()); end
    endtask

    task automatic test_reset_mid();
        im_ready = 1'b0;
        clear_q();
        do_start(32'h0000_0400);
        send_beat(5'd4, 5'd4, 5'd5, 5'd6, 5'd9, 16'h0, 26'h0, 1'b0);
        total++; if (im_we !== 1'b1 || im_wdata !== 32'h0085_3026) begin bad++; $display("FAIL mid_pending: we=%b data=%h want 1 00853026", im_we, im_wdata); end
        #2;
        resetn = 1'b0;
        #1;
        total++; if (im_we !== 1'b0 || im_addr !== 32'h0 || im_wdata !== 32'h0) begin
            bad++; $display("FAIL mid_async: we=%b addr=%h data=%h want 0 0 0", im_we, im_addr, im_wdata); end
        total++; if ({busy, in_ready, done} !== 3'b0 || count !== 8'd0) begin
            bad++; $display("FAIL mid_flags: busy/rdy/done=%b count=%0d want 000 0", {busy, in_ready, done}, count); end
        im_ready = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || im_we !== 1'b0 || wq_addr.size() != 0) begin
            bad++; $display("FAIL mid_after: busy=%b we=%b writes=%0d want 0 0 0", busy, im_we, wq_addr.size()); end
        do_start(32'h0000_0503);  // low address bits dropped
        send_beat(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b1);
        wait_done();
        total++; if (wq_addr.size() != 1) begin bad++; $display("FAIL mid_nwrites: got %0d want 1", wq_addr.size()); end
        else begin
            total++; if (wq_addr[0] !== 32'h500 || wq_data[0] !== 32'h0FFF_FFFF) begin
                bad++; $display("FAIL mid_resume: addr=%h data=%h want 00000500 0fffffff", wq_addr[0], wq_data[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_encode();
        test_stall();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
